// File: rtl/soc_run_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_run_pkg
//  Description : Shared types and constants for the SoC run controller.
//                - state_t      : run controller state encoding (2 bits)
//                - INST_EBREAK  : RISC-V ebreak encoding, default halt marker
//                - DEF_CNT_WIDTH: default cycle/instruction counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_run_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] INST_EBREAK   = 32'h0010_0073;
    localparam int          DEF_CNT_WIDTH = 32;

endpackage : soc_run_pkg
`default_nettype wire

// File: rtl/soc_run_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : soc_run_cnt
//  Description : Saturating up-counter with synchronous clear and enable.
//                Holds at all-ones instead of wrapping.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset (count -> 0)
//                clr    - synchronous clear, has priority over en
//                en     - count enable
//                count  - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_run_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != c_max)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule : soc_run_cnt
`default_nettype wire

// File: rtl/soc_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : soc_run_ctrl
//  Description : Run controller for SoC bring-up/regression. Holds the core
//                in reset for RST_CYCLES, runs it under a cycle budget and
//                watches the commit stream for the halt instruction. Reports
//                done/pass/timeout plus cycle and instruction counts.
//  Ports       : i_sys_clk      - system clock
//                i_sys_rst_n    - asynchronous active-low reset
//                i_restart      - pulse in S_DONE to re-run the test
//                i_commit_vld   - core retired an instruction
//                i_commit_inst  - retired instruction encoding
//                i_a0_data      - a0 value, valid with i_commit_vld
//                o_core_rst_n   - registered active-low reset to the core
//                o_done         - test finished (sticky)
//                o_pass         - halt seen with a0 == 0
//                o_timeout      - budget exhausted without halt
//                o_cycle_cnt    - cycles spent running
//                o_inst_cnt     - commits counted while running
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_run_ctrl
    import soc_run_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int          RST_CYCLES = 4,
    parameter int          MAX_CYCLES = 100,
    parameter logic [31:0] HALT_INST  = INST_EBREAK
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_restart,
    input  logic                  i_commit_vld,
    input  logic [DATA_WIDTH-1:0] i_commit_inst,
    input  logic [DATA_WIDTH-1:0] i_a0_data,
    output logic                  o_core_rst_n,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [CNT_WIDTH-1:0]  o_cycle_cnt,
    output logic [CNT_WIDTH-1:0]  o_inst_cnt
);

    // Reset counter only needs to reach RST_CYCLES-1.
    localparam int                   c_rc_w       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_rc_w-1:0]    c_rst_last   = c_rc_w'(RST_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_halt      = DATA_WIDTH'(HALT_INST);
    localparam bit                   c_has_budget = (MAX_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] c_max_last   = CNT_WIDTH'(MAX_CYCLES - 1);

    state_t              r_state;
    logic [c_rc_w-1:0]   r_rst_cnt;

    logic w_run;
    logic w_halt;
    logic w_timeout;
    logic w_restart;
    logic w_cyc_en;
    logic w_inst_en;

    assign w_run     = (r_state == S_RUN);
    assign w_halt    = w_run && i_commit_vld && (i_commit_inst == c_halt);
    // Halt has priority: a halt on the last budget cycle is not a timeout.
    assign w_timeout = w_run && c_has_budget && (o_cycle_cnt == c_max_last) && !w_halt;
    assign w_restart = (r_state == S_DONE) && i_restart;

    // The terminating cycle does not advance the cycle count, so the frozen
    // value equals the count seen on that cycle (budget-1 on timeout).
    assign w_cyc_en  = w_run && !w_halt && !w_timeout;
    // The halting commit itself is counted.
    assign w_inst_en = w_run && i_commit_vld;

    soc_run_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_cycle_cnt (
        .clk   (i_sys_clk),
        .rst_n (i_sys_rst_n),
        .clr   (w_restart),
        .en    (w_cyc_en),
        .count (o_cycle_cnt)
    );

    soc_run_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_inst_cnt (
        .clk   (i_sys_clk),
        .rst_n (i_sys_rst_n),
        .clr   (w_restart),
        .en    (w_inst_en),
        .count (o_inst_cnt)
    );

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state      <= S_RST;
            r_rst_cnt    <= '0;
            o_core_rst_n <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_RST: begin
                    o_core_rst_n <= 1'b0;
                    if (r_rst_cnt == c_rst_last) begin
                        r_state      <= S_RUN;
                        r_rst_cnt    <= '0;
                        o_core_rst_n <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + c_rc_w'(1);
                    end
                end
                S_RUN: begin
                    o_core_rst_n <= 1'b1;
                    if (w_halt) begin
                        r_state   <= S_DONE;
                        o_done    <= 1'b1;
                        o_pass    <= (i_a0_data == '0);
                        o_timeout <= 1'b0;
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        o_done    <= 1'b1;
                        o_pass    <= 1'b0;
                        o_timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_restart) begin
                        r_state      <= S_RST;
                        r_rst_cnt    <= '0;
                        o_core_rst_n <= 1'b0;
                        o_done       <= 1'b0;
                        o_pass       <= 1'b0;
                        o_timeout    <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_RST;
                    r_rst_cnt    <= '0;
                    o_core_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule : soc_run_ctrl
`default_nettype wire
